arith_cmd_sequencer: RTL and testbench

Initiator side of the synchronous arithmetic unit interface. Accepts operation commands (A, B, op) over a valid/ready handshake and drives them onto the arithmetic unit's operand/opcode inputs. Captures the unit's registered result and 4-bit status, and buffers completed responses in a small FIFO with a valid/ready output. Also keeps a saturating error counter from the status ERROR bit.

---
 rtl/arith_cmd_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_arith_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_cmd_sequencer.sv
// arith_cmd_sequencer
//
// Initiator side of the synchronous arithmetic unit interface. A command
// (A, B, op) is accepted over a valid/ready handshake, forwarded on registered
// operand/opcode outputs, and the unit's registered result and status are
// captured two edges later and pushed into a small response FIFO. The FIFO
// head is presented show-ahead on a valid/ready output. A saturating counter
// tracks responses whose status ERROR bit was set.
//
// Optional build macro: ALU_CHECK_EN
//   When defined, every captured non-error response has its ZEROS,
//   NOT_EVEN_ZERO and OVERFLOW status bits cross-checked against the
//   result; any inconsistency sets the sticky o_chk_fail flag.
//   When undefined, o_chk_fail is tied low and no check logic exists.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready   command handshake
//   i_cmd_A/B/op              command operands and opcode
//   o_alu_A/B/op              registered operands/opcode to arithmetic unit
//   i_alu_result/status       registered result/status from arithmetic unit
//   o_rsp_valid/i_rsp_ready   response FIFO head handshake
//   o_rsp_result/status/op    response FIFO head contents
//   o_busy                    command in flight (EXEC or WAIT)
//   o_err_count               saturating count of ERROR responses
//   o_chk_fail                sticky status-consistency failure

module arith_cmd_sequencer #(
    parameter int BITS       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [BITS-1:0]      i_cmd_A,
    input  logic [BITS-1:0]      i_cmd_B,
    input  logic [1:0]           i_cmd_op,
    output logic [BITS-1:0]      o_alu_A,
    output logic [BITS-1:0]      o_alu_B,
    output logic [1:0]           o_alu_op,
    input  logic [BITS-1:0]      i_alu_result,
    input  logic [3:0]           i_alu_status,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [BITS-1:0]      o_rsp_result,
    output logic [3:0]           o_rsp_status,
    output logic [1:0]           o_rsp_op,
    output logic                 o_busy,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic                 o_chk_fail
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic push;
    logic pop;

    logic [1:0]       pending_op;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W-1:0] count_next;

    logic [BITS-1:0] mem_result [FIFO_DEPTH];
    logic [3:0]      mem_status [FIFO_DEPTH];
    logic [1:0]      mem_op     [FIFO_DEPTH];

    // Sequencing FSM: next state, admission and handshake decode.
    // Ready is masked by reset so every output reads 0 while reset is held.
    always_comb begin
        state_next  = state;
        o_cmd_ready = 1'b0;
        accept      = 1'b0;
        push        = 1'b0;
        case (state)
            S_IDLE: begin
                o_cmd_ready = !i_reset && (count < DEPTH_C);
                accept      = i_cmd_valid && !i_reset && (count < DEPTH_C);
                if (accept) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                push       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_busy      = (state == S_EXEC) || (state == S_WAIT);
    assign o_rsp_valid = (count != '0);
    assign pop         = o_rsp_valid && i_rsp_ready;

    // FIFO bookkeeping. A push can never find the FIFO full because the
    // count was checked at admission and can only have dropped since.
    always_comb begin
        rd_ptr_next     = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        count_after_pop = pop ? (count - CNT_W'(1)) : count;
        count_next      = push ? (count_after_pop + CNT_W'(1)) : count_after_pop;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            o_alu_A    <= '0;
            o_alu_B    <= '0;
            o_alu_op   <= '0;
            pending_op <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                o_alu_A    <= i_cmd_A;
                o_alu_B    <= i_cmd_B;
                o_alu_op   <= i_cmd_op;
                pending_op <= i_cmd_op;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    // Storage array carries no reset; validity is tracked by count alone.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_result[wr_ptr] <= i_alu_result;
            mem_status[wr_ptr] <= i_alu_status;
            mem_op[wr_ptr]     <= pending_op;
        end
    end

    // Show-ahead head registers. They load the entry that will be at the
    // head after this edge; when that entry is the one being pushed into an
    // otherwise empty FIFO it is taken straight from the inputs. When the
    // FIFO goes empty the registers keep the last value presented.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_rsp_result <= '0;
            o_rsp_status <= '0;
            o_rsp_op     <= '0;
        end else if (count_next != '0) begin
            if (push && (count_after_pop == '0)) begin
                o_rsp_result <= i_alu_result;
                o_rsp_status <= i_alu_status;
                o_rsp_op     <= pending_op;
            end else begin
                o_rsp_result <= mem_result[rd_ptr_next];
                o_rsp_status <= mem_status[rd_ptr_next];
                o_rsp_op     <= mem_op[rd_ptr_next];
            end
        end
    end

    // Saturating count of captured responses flagged with ERROR.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_err_count <= '0;
        end else if (push && i_alu_status[3] && (o_err_count != ERR_MAX)) begin
            o_err_count <= o_err_count + ERR_CNT_W'(1);
        end
    end

`ifdef ALU_CHECK_EN
    logic exp_zeros;
    logic exp_nez;
    logic status_bad;

    // Consistency of the flag bits against the captured result; only
    // meaningful when the unit did not report an error.
    always_comb begin
        exp_zeros  = (i_alu_result == '0);
        exp_nez    = ^(~i_alu_result);
        status_bad = (i_alu_status[1] != exp_zeros) ||
                     (i_alu_status[2] != exp_nez)   ||
                     i_alu_status[0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_chk_fail <= 1'b0;
        end else if (push && !i_alu_status[3] && status_bad) begin
            o_chk_fail <= 1'b1;
        end
    end
`else
    assign o_chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_arith_cmd_sequencer.sv
// tb_arith_cmd_sequencer
//
// Randomized bench for arith_cmd_sequencer. A stand-in arithmetic unit
// answers from the sequencer's operand outputs. Expected behaviour comes
// from a transaction-level model: each accepted command becomes a queued
// response that is available three cycles after acceptance, commands are
// admitted only when the sequencer is idle and fewer than FIFO_DEPTH
// responses are outstanding, and responses leave in order.
// ALU_CHECK_EN, when defined for the build, also enables the model of the
// sticky consistency flag.

module tb_arith_cmd_sequencer;

    localparam int BITS  = 32;
    localparam int DEPTH = 4;
    localparam int ERRW  = 2;
    localparam int ERR_MAX = (1 << ERRW) - 1;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b0;
    logic            i_cmd_valid = 1'b0;
    logic            o_cmd_ready;
    logic [BITS-1:0] i_cmd_A = '0;
    logic [BITS-1:0] i_cmd_B = '0;
    logic [1:0]      i_cmd_op = '0;
    logic [BITS-1:0] o_alu_A;
    logic [BITS-1:0] o_alu_B;
    logic [1:0]      o_alu_op;
    logic [BITS-1:0] i_alu_result = '0;
    logic [3:0]      i_alu_status = '0;
    logic            o_rsp_valid;
    logic            i_rsp_ready = 1'b0;
    logic [BITS-1:0] o_rsp_result;
    logic [3:0]      o_rsp_status;
    logic [1:0]      o_rsp_op;
    logic            o_busy;
    logic [ERRW-1:0] o_err_count;
    logic            o_chk_fail;

    arith_cmd_sequencer #(
        .BITS(BITS),
        .FIFO_DEPTH(DEPTH),
        .ERR_CNT_W(ERRW)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_A(i_cmd_A),
        .i_cmd_B(i_cmd_B),
        .i_cmd_op(i_cmd_op),
        .o_alu_A(o_alu_A),
        .o_alu_B(o_alu_B),
        .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result),
        .i_alu_status(i_alu_status),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_result(o_rsp_result),
        .o_rsp_status(o_rsp_status),
        .o_rsp_op(o_rsp_op),
        .o_busy(o_busy),
        .o_err_count(o_err_count),
        .o_chk_fail(o_chk_fail)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [BITS-1:0] result;
        logic [3:0]      status;
        logic [1:0]      op;
        int              avail;
    } rsp_t;

    rsp_t            exp_q[$];
    int              cyc = 0;
    int              last_acc = -100;
    int              err_total = 0;
    int              checks = 0;
    int              errors = 0;
    logic            exp_chk = 1'b0;
    logic            exp_valid;
    logic            exp_ready;
    logic [BITS-1:0] exp_alu_A = '0;
    logic [BITS-1:0] exp_alu_B = '0;
    logic [1:0]      exp_alu_op = '0;
    logic [BITS-1:0] last_result = '0;
    logic [3:0]      last_status = '0;
    logic [1:0]      last_op = '0;
    logic            mid_reset_hit = 1'b0;

    // Stand-in arithmetic unit: returns {result, status}. Error responses
    // carry arbitrary low status bits; some non-error responses carry a
    // spurious OVERFLOW so the consistency check has something to catch.
    function automatic logic [BITS+3:0] alu_model(input logic [BITS-1:0] a,
                                                  input logic [BITS-1:0] b,
                                                  input logic [1:0] op);
        logic [BITS-1:0] r;
        logic            err;
        case (op)
            2'b00:   r = a;
            2'b01:   r = ($signed(a) > $signed(b)) ? BITS'(1) :
                         (($signed(a) == $signed(b)) ? '0 : '1);
            2'b10:   r = b;
            default: r = a << b[4:0];
        endcase
        err = (a[2:0] == 3'b111);
        if (err) return {r, 1'b1, a[5:3]};
        return {r, 1'b0, ^(~r), (r == '0), a[6] & a[5] & a[4]};
    endfunction

    function automatic logic [BITS-1:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return BITS'($urandom_range(0, 15));
            default: return BITS'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_cycle();
        int  age;
        logic busy;
        foreach (exp_q[i]) begin
            if (exp_q[i].avail == cyc) begin
                if (exp_q[i].status[3] && err_total < ERR_MAX) err_total++;
`ifdef ALU_CHECK_EN
                if (!exp_q[i].status[3] &&
                    ((exp_q[i].status[1] != (exp_q[i].result == '0)) ||
                     (exp_q[i].status[2] != ^(~exp_q[i].result)) ||
                     exp_q[i].status[0]))
                    exp_chk = 1'b1;
`endif
            end
        end
        age       = cyc - last_acc;
        busy      = (age == 1) || (age == 2);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        exp_ready = !busy && (exp_q.size() < DEPTH);
        checkOutput("busy", 64'(o_busy), 64'(busy));
        checkOutput("cmd_ready", 64'(o_cmd_ready), 64'(exp_ready));
        checkOutput("rsp_valid", 64'(o_rsp_valid), 64'(exp_valid));
        checkOutput("err_count", 64'(o_err_count), 64'(err_total));
        checkOutput("chk_fail", 64'(o_chk_fail), 64'(exp_chk));
        checkOutput("alu_A", 64'(o_alu_A), 64'(exp_alu_A));
        checkOutput("alu_B", 64'(o_alu_B), 64'(exp_alu_B));
        checkOutput("alu_op", 64'(o_alu_op), 64'(exp_alu_op));
        if (exp_valid) begin
            checkOutput("rsp_result", 64'(o_rsp_result), 64'(exp_q[0].result));
            checkOutput("rsp_status", 64'(o_rsp_status), 64'(exp_q[0].status));
            checkOutput("rsp_op", 64'(o_rsp_op), 64'(exp_q[0].op));
        end else begin
            checkOutput("rsp_result_hold", 64'(o_rsp_result), 64'(last_result));
            checkOutput("rsp_status_hold", 64'(o_rsp_status), 64'(last_status));
            checkOutput("rsp_op_hold", 64'(o_rsp_op), 64'(last_op));
        end
    endtask

    // Assert reset (possibly mid-command), check the outputs while it is
    // held, release it on the next falling edge and clear the model.
    task automatic do_reset();
        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b0;
        #1;
        checkOutput("rst_cmd_ready", 64'(o_cmd_ready), 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        checkOutput("rst_alu_A", 64'(o_alu_A), 64'd0);
        checkOutput("rst_alu_B", 64'(o_alu_B), 64'd0);
        checkOutput("rst_alu_op", 64'(o_alu_op), 64'd0);
        checkOutput("rst_rsp_result", 64'(o_rsp_result), 64'd0);
        checkOutput("rst_rsp_status", 64'(o_rsp_status), 64'd0);
        checkOutput("rst_rsp_op", 64'(o_rsp_op), 64'd0);
        checkOutput("rst_err_count", 64'(o_err_count), 64'd0);
        checkOutput("rst_chk_fail", 64'(o_chk_fail), 64'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        exp_q.delete();
        last_acc    = -100;
        err_total   = 0;
        exp_chk     = 1'b0;
        exp_alu_A   = '0;
        exp_alu_B   = '0;
        exp_alu_op  = '0;
        last_result = '0;
        last_status = '0;
        last_op     = '0;
    endtask

    // Drive the inputs for the coming rising edge. Phases: directed first
    // command, FIFO fill with the consumer stalled, a single pop, a random
    // mix, then a drain.
    task automatic applyStimulus(input int n);
        if (n == 0) begin
            i_cmd_valid = 1'b1;
            i_cmd_A     = BITS'(5);
            i_cmd_B     = BITS'(3);
            i_cmd_op    = 2'b01;
        end else begin
            i_cmd_valid = (n < 60) ? 1'b1 :
                          (n < 400) ? ($urandom_range(0, 9) < 7) : 1'b0;
            i_cmd_A     = rand_operand();
            i_cmd_B     = rand_operand();
            i_cmd_op    = 2'($urandom_range(0, 3));
        end
        if (n < 40)       i_rsp_ready = 1'b0;
        else if (n == 40) i_rsp_ready = 1'b1;
        else if (n < 60)  i_rsp_ready = 1'b0;
        else if (n < 400) i_rsp_ready = $urandom_range(0, 1) == 1;
        else              i_rsp_ready = 1'b1;
        {i_alu_result, i_alu_status} = alu_model(o_alu_A, o_alu_B, o_alu_op);
    endtask

    initial begin
        rsp_t e;
        do_reset();
        for (int n = 0; n < 460; n++) begin
            @(negedge i_clk);
            check_cycle();
            if (!mid_reset_hit && n >= 200 && (cyc - last_acc) == 2) begin
                mid_reset_hit = 1'b1;
                do_reset();
                continue;
            end
            applyStimulus(n);
            if (i_rsp_ready && exp_valid) begin
                e = exp_q.pop_front();
                last_result = e.result;
                last_status = e.status;
                last_op     = e.op;
            end
            if (i_cmd_valid && exp_ready) begin
                {e.result, e.status} = alu_model(i_cmd_A, i_cmd_B, i_cmd_op);
                e.op  = i_cmd_op;
                e.avail = cyc + 3;
                exp_q.push_back(e);
                exp_alu_A  = i_cmd_A;
                exp_alu_B  = i_cmd_B;
                exp_alu_op = i_cmd_op;
                last_acc   = cyc;
            end
            cyc++;
        end
        checkOutput("mid_reset_reached", 64'(mid_reset_hit), 64'd1);
        checkOutput("drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
